tdc_measure_ctrl: RTL

TDC_MEASURE_CTRL -- requirements
Module: tdc_measure_ctrl

---
 rtl/tdc_measure_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: coarse time-to-digital measurement controller.
// It waits for an arm request, then times the interval from a start pulse to
// a stop pulse in clk cycles, with a per-measurement timeout.
// It also pulses fine_latch so the fine delay-line taps can be captured.
// Optional macro TDC_AUTO_REARM_EN: after a result is consumed, the block
// goes back to ARMED and keeps the previous timeout limit, instead of
// returning to IDLE.
module tdc_measure_ctrl #(
  parameter int unsigned CNT_W = 16  // valid range 4..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             start_pulse,
  input  logic             stop_pulse,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic             busy,
  output logic             fine_latch,
  output logic [CNT_W-1:0] result_count,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_result;
  logic             r_ovf;
  logic             r_fine;

  logic [CNT_W-1:0] w_count_inc;
  logic             w_arm_acc;
  logic             w_start_acc;
  logic             w_stop_acc;
  logic             w_timeout;

  // counter + 1 is the interval length if the measurement ends on this cycle
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_arm_acc   = (r_state == S_IDLE)  && arm;
  assign w_start_acc = (r_state == S_ARMED) && start_pulse;
  assign w_stop_acc  = (r_state == S_COUNT) && stop_pulse;
  // stop wins over timeout when both land on the same cycle
  assign w_timeout   = (r_state == S_COUNT) && !stop_pulse && (w_count_inc == r_limit);

  assign busy         = (r_state == S_ARMED) || (r_state == S_COUNT);
  assign result_valid = (r_state == S_DONE);
  assign fine_latch   = r_fine;
  assign result_count = r_result;
  assign result_ovf   = r_ovf;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state selection; abort overrides every other request
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (arm)                      w_state_nxt = S_ARMED;
        S_ARMED: if (start_pulse)              w_state_nxt = S_COUNT;
        S_COUNT: if (w_stop_acc || w_timeout)  w_state_nxt = S_DONE;
        S_DONE: begin
          if (result_ready) begin
`ifdef TDC_AUTO_REARM_EN
            w_state_nxt = S_ARMED;
`else
            w_state_nxt = S_IDLE;
`endif
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // timeout limit, coarse counter, result fields and fine-latch pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count  <= '0;
      r_limit  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_fine   <= 1'b0;
    end else begin
      r_fine <= 1'b0;
      if (abort) begin
        r_count <= '0;
      end else begin
        // a zero timeout means the longest interval the counter can represent
        if (w_arm_acc) r_limit <= (cfg_timeout == '0) ? '1 : cfg_timeout;
        if (w_start_acc) begin
          r_count <= '0;
          r_fine  <= 1'b1;
        end
        if (w_stop_acc) begin
          r_result <= w_count_inc;
          r_ovf    <= 1'b0;
          r_fine   <= 1'b1;
        end else if (w_timeout) begin
          r_result <= r_limit;
          r_ovf    <= 1'b1;
        end else if (r_state == S_COUNT) begin
          r_count <= w_count_inc;
        end
      end
    end
  end

endmodule
